// File: rtl/sync_pkg.sv
// ============================================================================
// Module : sync_pkg
// Brief  : Shared defaults and helpers for the sync_debounce block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sync_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;

    // Counter must hold 0..DEBOUNCE_CYCLES-1; a zero-width vector is not legal.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_debounce_ch.sv
// ============================================================================
// Module : sync_debounce_ch
// Brief  : One channel: synchronizer chain, debounce counter, level and ticks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_debounce_ch
    import sync_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_tick_nxt
);

    localparam int                CNT_W      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_rise;
    logic                   r_fall;

    logic w_syncd;
    logic w_differs;
    logic w_accept;

    assign w_syncd   = r_sync[SYNC_STAGES-1];
    assign w_differs = (w_syncd != r_level);
    assign w_accept  = w_differs && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= {SYNC_STAGES{RESET_BIT}};
            r_cnt   <= '0;
            r_level <= RESET_BIT;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_rise <= w_accept &  w_syncd;
            r_fall <= w_accept & ~w_syncd;
            // Any sample matching the current level restarts the filter.
            if (!w_differs) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= w_syncd;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_level    = r_level;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_tick_nxt = w_accept;

endmodule

`default_nettype wire

// File: rtl/sync_debounce.sv
// ============================================================================
// Module : sync_debounce
// Brief  : Multi-channel synchronizer + debouncer with rise/fall/any ticks.
//          SYNC_DEBOUNCE_STICKY_EN adds sticky tick capture with a clear input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_debounce
    import sync_pkg::*;
#(
    parameter int                  CHANNELS        = 4,
    parameter int                  SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int                  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [CHANNELS-1:0] RESET_VAL       = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
`ifdef SYNC_DEBOUNCE_STICKY_EN
    input  logic                sticky_clr,
    output logic [CHANNELS-1:0] rise_sticky,
    output logic [CHANNELS-1:0] fall_sticky,
`endif
    output logic [CHANNELS-1:0] sync_out,
    output logic [CHANNELS-1:0] rise_edge_tick,
    output logic [CHANNELS-1:0] fall_edge_tick,
    output logic                any_edge_tick
);

    logic [CHANNELS-1:0] w_tick_nxt;
    logic                r_any;

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
            sync_debounce_ch #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_BIT       (RESET_VAL[g])
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .i_async    (async_in[g]),
                .o_level    (sync_out[g]),
                .o_rise     (rise_edge_tick[g]),
                .o_fall     (fall_edge_tick[g]),
                .o_tick_nxt (w_tick_nxt[g])
            );
        end
    endgenerate

    // Registered from the channels' pre-register accepts so it lines up with their ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |w_tick_nxt;
        end
    end

    assign any_edge_tick = r_any;

`ifdef SYNC_DEBOUNCE_STICKY_EN
    logic [CHANNELS-1:0] r_rise_sticky;
    logic [CHANNELS-1:0] r_fall_sticky;

    // A tick in the same cycle as the clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise_sticky <= '0;
            r_fall_sticky <= '0;
        end else begin
            r_rise_sticky <= (r_rise_sticky & ~{CHANNELS{sticky_clr}}) | rise_edge_tick;
            r_fall_sticky <= (r_fall_sticky & ~{CHANNELS{sticky_clr}}) | fall_edge_tick;
        end
    end

    assign rise_sticky = r_rise_sticky;
    assign fall_sticky = r_fall_sticky;
`else
    // Without sticky capture the block is purely level + tick outputs.
`endif

endmodule

`default_nettype wire
